// File: rtl/mips16_trace_tx.sv
// ----------------------------------------------------------------------------
// mips16_trace_tx
//
// Samples the MIPS16 program counter and ALU result. Each time the pc changes,
// or on the first enabled sample after reset, it buffers the {pc, alu} pair in
// a small FIFO. The transmitter drains the FIFO one entry at a time and sends
// each entry on a UART line as a 5-byte frame:
//   0xA5, pc[15:8], pc[7:0], alu[15:8], alu[7:0]
// Each byte is sent as a start bit, 8 data bits (LSB first) and a stop bit.
//
// Optional feature: defining the macro TRACE_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit, giving 11 bit times per byte.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit
//   FIFO_DEPTH   : number of buffered trace entries (power of two, 2..16)
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   reset      : asynchronous active-low reset
//   capture_en : enables trace sampling
//   pc_in      : processor program counter
//   alu_in     : processor ALU result
//   tx         : UART serial output, idles high
//   busy       : high while a frame is being transmitted
//   overflow   : sticky flag, set when a trace entry is dropped
//   fifo_count : number of entries currently buffered
// ----------------------------------------------------------------------------
module mips16_trace_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic [15:0] pc_in,
    input  logic [15:0] alu_in,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [4:0]  fifo_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    DEPTH5   = 5'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef TRACE_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // Capture side
    logic [15:0]   prev_pc_reg;
    logic          first_reg;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [4:0]    count_reg;
    logic          overflow_reg;

    // Transmit side
    logic [2:0]    state_reg;
    logic [CW-1:0] clk_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    byte_idx_reg;
    logic [7:0]    byte_reg;
    logic [31:0]   frame_reg;

    logic capture;
    logic fifo_full;
    logic fifo_empty;
    logic bit_done;
    logic frame_done;
    logic pop;
    logic push;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] f);
        case (idx)
            3'd0:    frame_byte = 8'hA5;
            3'd1:    frame_byte = f[31:24];
            3'd2:    frame_byte = f[23:16];
            3'd3:    frame_byte = f[15:8];
            default: frame_byte = f[7:0];
        endcase
    endfunction

    assign capture    = capture_en && (first_reg || (pc_in != prev_pc_reg));
    assign fifo_full  = (count_reg == DEPTH5);
    assign fifo_empty = (count_reg == 5'd0);
    assign bit_done   = (clk_cnt_reg == BIT_LAST);
    assign frame_done = (state_reg == S_STOP) && bit_done && (byte_idx_reg == 3'd4);
    // A new frame is started either from idle or straight out of the last stop
    // bit, so consecutive frames leave no gap on the line.
    assign pop        = !fifo_empty && ((state_reg == S_IDLE) || frame_done);
    // A full FIFO still takes the entry when a slot is freed in the same cycle.
    assign push       = capture && (!fifo_full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_reg  <= 16'd0;
            first_reg    <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= 5'd0;
            overflow_reg <= 1'b0;
        end else begin
            prev_pc_reg <= pc_in;
            if (capture_en)
                first_reg <= 1'b0;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 5'd1;
            else if (pop && !push)
                count_reg <= count_reg - 5'd1;
            if (capture && !push)
                overflow_reg <= 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {pc_in, alu_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= 3'd0;
            byte_idx_reg <= 3'd0;
            byte_reg     <= 8'd0;
            frame_reg    <= 32'd0;
        end else begin
            if (state_reg == S_IDLE || bit_done)
                clk_cnt_reg <= '0;
            else
                clk_cnt_reg <= clk_cnt_reg + 1'b1;

            if (pop) begin
                frame_reg    <= mem[rd_ptr_reg];
                byte_reg     <= 8'hA5;
                byte_idx_reg <= 3'd0;
                state_reg    <= S_START;
            end else begin
                case (state_reg)
                    S_IDLE: state_reg <= S_IDLE;
                    S_START: begin
                        if (bit_done) begin
                            state_reg   <= S_DATA;
                            bit_idx_reg <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (bit_done) begin
                            if (bit_idx_reg == 3'd7) begin
`ifdef TRACE_PARITY_EN
                                state_reg <= S_PARITY;
`else
                                state_reg <= S_STOP;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end
                        end
                    end
`ifdef TRACE_PARITY_EN
                    S_PARITY: begin
                        if (bit_done)
                            state_reg <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        if (bit_done) begin
                            if (byte_idx_reg == 3'd4) begin
                                state_reg <= S_IDLE;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 3'd1;
                                byte_reg     <= frame_byte(byte_idx_reg + 3'd1, frame_reg);
                                state_reg    <= S_START;
                            end
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            S_START:  tx = 1'b0;
            S_DATA:   tx = byte_reg[bit_idx_reg];
`ifdef TRACE_PARITY_EN
            S_PARITY: tx = ^byte_reg;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign busy       = (state_reg != S_IDLE);
    assign overflow   = overflow_reg;
    assign fifo_count = count_reg;

endmodule

// File: doc/mips16_trace_tx.md
MIPS16_TRACE_TX -- requirements
Module: mips16_trace_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of trace entries buffered (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port capture_en, input, 1, high = trace sampling enabled.
REQ-006 SHALL have port pc_in, input, 16, processor pc_out.
REQ-007 SHALL have port alu_in, input, 16, processor alu_result.
REQ-008 SHALL have port tx, output, 1, UART serial line, idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is being transmitted.
REQ-010 SHALL have port overflow, output, 1, sticky flag indicating a dropped trace entry.
REQ-011 SHALL have port fifo_count, output, 5, current number of buffered entries.

Function
REQ-012 SHALL register pc_in each cycle; a capture event occurs when capture_en=1 and (pc_in differs from the registered previous pc or it is the first enabled sample since reset).
REQ-013 SHALL push {pc_in, alu_in} (32 bits) into the FIFO on a capture event in that same cycle.
REQ-014 SHALL, on a capture event with FIFO full and no pop in that cycle, drop the entry and set overflow=1.
REQ-015 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; fifo_count is then unchanged.
REQ-016 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-017 SHALL, when idle and fifo_count>0, pop one entry and transmit a 5-byte frame: 0xA5, pc[15:8], pc[7:0], alu[15:8], alu[7:0].
REQ-018 SHALL serialise each byte as start bit (0), 8 data bits LSB first, then stop bit (1), with each bit held for exactly CLKS_PER_BIT cycles.
REQ-019 SHALL implement bit FSM states IDLE -> START -> DATA (8 bits) -> STOP -> (next byte START, or IDLE after byte 4).
REQ-020 SHALL send consecutive bytes of a frame back to back, and SHALL begin the next frame on the cycle after the last STOP bit if the FIFO is non-empty.
REQ-021 SHALL assert busy from the cycle the entry is popped through the last cycle of the final STOP bit.
REQ-022 SHALL let capture_en deassertion only block new captures; buffered entries still drain.
REQ-023 SHALL keep fifo_count equal to the number of pushes minus the number of pops, and never above FIFO_DEPTH.

Reset
REQ-024 SHALL, while reset=0, force tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, pointers=0, and first-sample flag set.
REQ-025 SHALL, on reset assertion mid-frame, abort the frame immediately and discard all buffered entries.
REQ-026 SHALL clear overflow only by reset.

Configuration
REQ-027 SHALL, when macro TRACE_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP via a PARITY state (11 bit times per byte).
REQ-028 SHALL, when TRACE_PARITY_EN is undefined, omit the PARITY state (10 bit times per byte).

Verification
REQ-029 SHALL cover: CLKS_PER_BIT=4, reset released, pc_in=0x0000, alu_in=0x1234, capture_en=1 -> tx emits 0xA5,0x00,0x00,0x12,0x34, 200 cycles, busy high for all 200.
REQ-030 SHALL cover: pc_in held at 0x0004 for 50 cycles -> exactly one entry captured, fifo_count peaks at 1.
REQ-031 SHALL cover: 10 distinct pc values on consecutive cycles, FIFO_DEPTH=8 -> 9 entries accepted (one pop frees a slot), 1 dropped, overflow=1, 9 frames transmitted in order.
REQ-032 SHALL cover: reset=0 asserted at cycle 60 of a frame -> tx=1 and busy=0 in the same cycle, fifo_count=0, no further frames.
REQ-033 SHALL cover: with TRACE_PARITY_EN defined, data byte 0xA5 -> parity bit 0 and frame length 220 cycles at CLKS_PER_BIT=4; byte 0x01 -> parity bit 1.
REQ-034 SHALL cover: capture_en=0 with pc changing -> fifo_count stays 0 and tx stays high.
